elixirchip_es1_spu_lut_arbiter: RTL and testbench
=================================================

Name: elixirchip_es1_spu_lut_arbiter

Overview:
Shares one elixirchip_es1_spu_op_lut instance between N_REQ requesters.
- Arbitrates requests round-robin and drives the LUT's address, clear and valid inputs.
- Carries the winning requester ID through a tag pipeline aligned with the LUT latency.
- Returns each looked-up value with its requester ID.
- Sits in the SPU between per-lane address generators and a shared table.

Parameters:
N_REQ, 4, number of requesters (2..16)
ID_BITS, $clog2(N_REQ), requester ID width
LATENCY, 1, latency of the attached LUT; must match its LATENCY parameter (>=1)
ADDR_BITS, 6, LUT address width
DATA_BITS, 8, LUT data width
DEVICE, "RTL", device name, passed through
SIMULATION, "false", simulation switch
DEBUG, "false", debug switch

Ports:
reset  input  1  synchronous reset, active-high
clk  input  1  clock
cke  input  1  clock enable; shared with the LUT
s_req_addr  input  N_REQ*ADDR_BITS  request address per requester; requester i uses bits [i*ADDR_BITS +: ADDR_BITS]
s_req_valid  input  N_REQ  request pending per requester
s_req_ready  output  N_REQ  one-hot grant; accept happens when valid & ready
lut_addr  output  ADDR_BITS  to LUT s_addr
lut_clear  output  1  to LUT s_clear
lut_valid  output  1  to LUT s_valid
lut_data  input  DATA_BITS  from LUT m_data
m_data  output  DATA_BITS  looked-up value
m_id  output  ID_BITS  requester ID of m_data
m_valid  output  1  m_data/m_id valid; no backpressure

Behaviour:
- Clocking: one clock, clk. Reset is synchronous and active-high, on port reset; every register clears on the first clk edge with reset=1.
- cke=0: all registers hold; s_req_ready=0; no accept occurs.
- Grant (combinational):
  - Among set s_req_valid bits, search upward from (last+1) mod N_REQ and wrap; the first hit wins.
  - s_req_ready[win]=cke; all other bits 0.
  - s_req_ready may depend combinationally on s_req_valid. It never depends on s_req_addr.
- Issue stage (registers, updates when cke=1):
  - With a winner: lut_addr<=addr[win], lut_valid<=1, lut_clear<=0, last<=win, tag<={1,win}.
  - With no request: lut_addr holds, lut_valid<=0, lut_clear<=1, tag<={0,0}. The LUT output therefore returns to CLEAR_DATA when idle.
- Tag pipe: LATENCY-stage shift of {valid,id}, advancing only when cke=1.
  - m_valid/m_id come from the pipe's last stage.
  - m_data = lut_data, passed through combinationally.
- Total latency from accept edge to m_valid: 1+LATENCY cke-enabled cycles.
- Throughput: one lookup per cke cycle. A requester holding valid is granted at least once every N_REQ enabled cycles.
- Reset values: lut_addr=0, lut_valid=0, lut_clear=1, m_valid=0, m_id=0, last=N_REQ-1 (requester 0 wins first).
- m_data is not registered here. After reset it equals the LUT's cleared output (CLEAR_DATA).
- Reset mid-operation: in-flight tags are discarded. m_valid=0 from the next edge; no stale result is emitted.
- Only one requester valid: it is granted every enabled cycle (back-to-back).
- ID wrap: last=N_REQ-1 continues the search at 0.

Optional Feature:
- Macro: ELIXIRCHIP_ES1_SPU_LUT_ARB_URGENT0_EN.
- Defined: requester 0 has absolute priority. If s_req_valid[0]=1 it wins regardless of last, and last is not updated. The remaining requesters stay round-robin.
- Undefined: pure round-robin as above.

Decomposition:
- Package elixirchip_es1_spu_lut_arb_pkg holds:
  - tag_t struct {logic valid; id} parameterised through ID_BITS.
  - function rr_pick(valid, last), returning the winner index and a found flag.
- One sub-module: elixirchip_es1_spu_lut_arb_tag_delay, a LATENCY-deep cke-gated shift register of tag_t with synchronous reset. This is the natural split.
- The bench instantiates the arbiter together with elixirchip_es1_spu_op_lut (identity table).

Test Plan:
1. Reset, then all requesters idle → lut_clear=1, lut_valid=0, m_valid=0, m_data=CLEAR_DATA(123).
2. All 4 requesters valid with addresses 5,10,20,40, cke=1, LATENCY=1 → grants in order 0,1,2,3,0; m_valid on the 2nd edge after each accept, with (m_id,m_data)=(0,5),(1,10),(2,20),(3,40).
3. Only requester 2 valid, addr=0x3F → granted every cycle; m_data=0x3F and m_id=2 continuously.
4. Random cke (10% low) with all requesters valid → no grant, pipe shift or m_valid change while cke=0; each ID's results appear in issue order; scoreboard matches 4096 lookups.
5. Reset asserted while 2 lookups are in flight → m_valid=0 after the reset edge; the next grant goes to requester 0.
6. URGENT0_EN defined, requesters 0 and 1 valid → requester 0 wins every cycle; dropping s_req_valid[0] gives requester 1 the grant next cycle.

Source files
------------

// File: rtl/elixirchip_es1_spu_lut_arb_pkg.sv
// Shared types and helpers for the SPU LUT arbiter.
// tag_t carries {valid, requester id} alongside a lookup. The id field is
// sized for the largest supported requester count (16), so one type serves
// every N_REQ. rr_pick performs the round-robin search over a zero-padded
// request vector.
package elixirchip_es1_spu_lut_arb_pkg;

    localparam int MAX_REQ     = 16;
    localparam int TAG_ID_BITS = 4;

    typedef struct packed {
        logic                   valid;
        logic [TAG_ID_BITS-1:0] id;
    } tag_t;

    typedef struct packed {
        logic                   found;
        logic [TAG_ID_BITS-1:0] idx;
    } pick_t;

    // Search upward from last+1 and wrap. Bits at or above N_REQ are zero,
    // so a mod-16 scan visits the same requesters in the same order as a
    // mod-N_REQ scan would.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0]     valid,
                                      input logic [TAG_ID_BITS-1:0] last);
        pick_t                  p;
        logic [TAG_ID_BITS-1:0] cand;
        p = '0;
        for (int i = 1; i <= MAX_REQ; i++) begin
            cand = last + TAG_ID_BITS'(i);
            if (!p.found && valid[cand]) begin
                p.found = 1'b1;
                p.idx   = cand;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/elixirchip_es1_spu_lut_arb_tag_delay.sv
// LATENCY-deep shift register of tag_t, advancing only when cke=1.
// Keeps the requester id aligned with the data leaving the shared LUT.
module elixirchip_es1_spu_lut_arb_tag_delay
    import elixirchip_es1_spu_lut_arb_pkg::*;
#(
    parameter int LATENCY = 1
)(
    input  logic reset,
    input  logic clk,
    input  logic cke,
    input  tag_t s_tag,
    output tag_t m_tag
);

    tag_t stage [LATENCY];

    // Shift the tag pipe on every enabled cycle.
    // NOTE: every stage is reset, unlike a data RAM: a leftover valid tag
    // would emit a stale result after reset, and the array is tiny.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage[i] <= '0;
            end
        end else if (cke) begin
            stage[0] <= s_tag;
            for (int i = 1; i < LATENCY; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign m_tag = stage[LATENCY-1];

endmodule

// File: rtl/elixirchip_es1_spu_lut_arbiter.sv
// Round-robin arbiter sharing one elixirchip_es1_spu_op_lut between N_REQ
// requesters. The grant is combinational; the issue stage registers the
// LUT address/valid/clear and a tag that travels through a LATENCY-deep
// pipe so the result returns with its requester id.
// Optional build macro ELIXIRCHIP_ES1_SPU_LUT_ARB_URGENT0_EN gives
// requester 0 absolute priority without disturbing the round-robin pointer.
module elixirchip_es1_spu_lut_arbiter
    import elixirchip_es1_spu_lut_arb_pkg::*;
#(
    parameter int    N_REQ      = 4,
    parameter int    ID_BITS    = $clog2(N_REQ),
    parameter int    LATENCY    = 1,
    parameter int    ADDR_BITS  = 6,
    parameter int    DATA_BITS  = 8,
    parameter string DEVICE     = "RTL",
    parameter string SIMULATION = "false",
    parameter string DEBUG      = "false"
)(
    input  logic                       reset,
    input  logic                       clk,
    input  logic                       cke,
    input  logic [N_REQ*ADDR_BITS-1:0] s_req_addr,
    input  logic [N_REQ-1:0]           s_req_valid,
    output logic [N_REQ-1:0]           s_req_ready,
    output logic [ADDR_BITS-1:0]       lut_addr,
    output logic                       lut_clear,
    output logic                       lut_valid,
    input  logic [DATA_BITS-1:0]       lut_data,
    output logic [DATA_BITS-1:0]       m_data,
    output logic [ID_BITS-1:0]         m_id,
    output logic                       m_valid
);

    // Pass-through identifiers; no behaviour in this block depends on them.
    localparam bit unused_pass_through = (DEVICE != "") || (SIMULATION != "") || (DEBUG != "");

    logic [MAX_REQ-1:0]     req_valid_pad;
    logic [TAG_ID_BITS-1:0] last;
    pick_t                  pick;
    logic                   urgent;
    logic [ADDR_BITS-1:0]   win_addr;
    tag_t                   issue_tag;
    tag_t                   out_tag;
    logic                   unused_tag_bits;

    assign req_valid_pad = MAX_REQ'(s_req_valid);

    // Pick the winner: round-robin, optionally overridden by requester 0.
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned and infers a latch.
    always_comb begin
        pick   = rr_pick(req_valid_pad, last);
        urgent = 1'b0;
`ifdef ELIXIRCHIP_ES1_SPU_LUT_ARB_URGENT0_EN
        if (s_req_valid[0]) begin
            pick.found = 1'b1;
            pick.idx   = '0;
            urgent     = 1'b1;
        end
`endif
    end

    // One-hot grant and winner address mux; the grant never looks at addresses.
    always_comb begin
        s_req_ready = '0;
        win_addr    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick.idx == TAG_ID_BITS'(i)) begin
                s_req_ready[i] = cke & pick.found;
                win_addr       = s_req_addr[i*ADDR_BITS +: ADDR_BITS];
            end
        end
    end

    // Issue stage: drive the LUT and launch the tag; clear the LUT when idle.
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            lut_addr  <= '0;
            lut_valid <= 1'b0;
            lut_clear <= 1'b1;
            last      <= TAG_ID_BITS'(N_REQ - 1);
            issue_tag <= '0;
        end else if (cke) begin
            if (pick.found) begin
                lut_addr  <= win_addr;
                lut_valid <= 1'b1;
                lut_clear <= 1'b0;
                issue_tag <= '{valid: 1'b1, id: pick.idx};
                if (!urgent) begin
                    last <= pick.idx;
                end
            end else begin
                lut_valid <= 1'b0;
                lut_clear <= 1'b1;
                issue_tag <= '0;
            end
        end
    end

    elixirchip_es1_spu_lut_arb_tag_delay #(
        .LATENCY (LATENCY)
    ) u_tag_delay (
        .reset (reset),
        .clk   (clk),
        .cke   (cke),
        .s_tag (issue_tag),
        .m_tag (out_tag)
    );

    assign m_valid         = out_tag.valid;
    assign m_id            = out_tag.id[ID_BITS-1:0];
    assign m_data          = lut_data;
    assign unused_tag_bits = ^out_tag.id;

endmodule

// File: tb/tb_elixirchip_es1_spu_lut_arbiter.sv
// Self-checking bench for elixirchip_es1_spu_lut_arbiter (N_REQ=4, LATENCY=1)
// attached to a behavioural identity-table LUT with CLEAR_DATA=123.
// Define ELIXIRCHIP_ES1_SPU_LUT_ARB_URGENT0_EN to also exercise the
// requester-0 priority build.
`timescale 1ns/1ps
module tb_elixirchip_es1_spu_lut_arbiter;

    localparam int N_REQ      = 4;
    localparam int ADDR_BITS  = 6;
    localparam int DATA_BITS  = 8;
    localparam int ID_BITS    = 2;
    localparam logic [7:0] CLEAR_DATA = 8'd123;

    typedef struct packed {
        logic       v;
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    logic                       reset;
    logic                       clk;
    logic                       cke;
    logic [N_REQ*ADDR_BITS-1:0] s_req_addr;
    logic [N_REQ-1:0]           s_req_valid;
    logic [N_REQ-1:0]           s_req_ready;
    logic [ADDR_BITS-1:0]       lut_addr;
    logic                       lut_clear;
    logic                       lut_valid;
    logic [DATA_BITS-1:0]       lut_data;
    logic [DATA_BITS-1:0]       m_data;
    logic [ID_BITS-1:0]         m_id;
    logic                       m_valid;

    int checks   = 0;
    int failures = 0;

    elixirchip_es1_spu_lut_arbiter #(
        .N_REQ     (N_REQ),
        .LATENCY   (1),
        .ADDR_BITS (ADDR_BITS),
        .DATA_BITS (DATA_BITS)
    ) dut (
        .reset       (reset),
        .clk         (clk),
        .cke         (cke),
        .s_req_addr  (s_req_addr),
        .s_req_valid (s_req_valid),
        .s_req_ready (s_req_ready),
        .lut_addr    (lut_addr),
        .lut_clear   (lut_clear),
        .lut_valid   (lut_valid),
        .lut_data    (lut_data),
        .m_data      (m_data),
        .m_id        (m_id),
        .m_valid     (m_valid)
    );

    // Stand-in for elixirchip_es1_spu_op_lut: identity table, LATENCY=1.
    always_ff @(posedge clk) begin
        if (reset) begin
            lut_data <= CLEAR_DATA;
        end else if (cke) begin
            if (lut_clear) begin
                lut_data <= CLEAR_DATA;
            end else if (lut_valid) begin
                lut_data <= {2'b00, lut_addr};
            end
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        reset       = 1'b1;
        cke         = 1'b1;
        s_req_valid = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        s_req_addr = '0;
        #1;
        checks++;
        if (lut_clear !== 1'b1 || lut_valid !== 1'b0 || lut_addr !== 6'd0) begin
            failures++;
            $display("FAIL reset_lut_ctrl: got clear=%b valid=%b addr=%0d, expected clear=1 valid=0 addr=0",
                     lut_clear, lut_valid, lut_addr);
        end
        checks++;
        if (m_valid !== 1'b0 || m_id !== 2'd0 || s_req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL reset_outputs: got m_valid=%b m_id=%0d ready=%b, expected 0 0 0000",
                     m_valid, m_id, s_req_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (lut_clear !== 1'b1 || lut_valid !== 1'b0 || m_valid !== 1'b0 || m_data !== CLEAR_DATA) begin
            failures++;
            $display("FAIL idle_after_reset: got clear=%b valid=%b m_valid=%b m_data=%0d, expected 1 0 0 123",
                     lut_clear, lut_valid, m_valid, m_data);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] addr_tab [4];
        logic [3:0] exp_ready;
        addr_tab = '{8'd5, 8'd10, 8'd20, 8'd40};
        do_reset();
        s_req_addr  = {6'd40, 6'd20, 6'd10, 6'd5};
        s_req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            #1;
            exp_ready = 4'b0001 << (k % 4);
            checks++;
            if (s_req_ready !== exp_ready) begin
                failures++;
                $display("FAIL rr_grant[%0d]: got ready=%b, expected %b", k, s_req_ready, exp_ready);
            end
            @(posedge clk);
            #1;
            if (k == 0) begin
                checks++;
                if (m_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL rr_latency: got m_valid=%b one edge after accept, expected 0", m_valid);
                end
            end else begin
                checks++;
                if (m_valid !== 1'b1 || m_id !== 2'((k - 1) % 4) || m_data !== addr_tab[(k - 1) % 4]) begin
                    failures++;
                    $display("FAIL rr_result[%0d]: got v=%b id=%0d data=%0d, expected v=1 id=%0d data=%0d",
                             k, m_valid, m_id, m_data, (k - 1) % 4, addr_tab[(k - 1) % 4]);
                end
            end
        end
    endtask

    task automatic test_single_requester();
        do_reset();
        s_req_addr           = '0;
        s_req_addr[12 +: 6]  = 6'h3F;
        s_req_valid          = 4'b0100;
        for (int k = 0; k < 6; k++) begin
            #1;
            checks++;
            if (s_req_ready !== 4'b0100) begin
                failures++;
                $display("FAIL single_grant[%0d]: got ready=%b, expected 0100", k, s_req_ready);
            end
            @(posedge clk);
            #1;
            if (k >= 1) begin
                checks++;
                if (m_valid !== 1'b1 || m_id !== 2'd2 || m_data !== 8'h3F || lut_addr !== 6'h3F) begin
                    failures++;
                    $display("FAIL single_result[%0d]: got v=%b id=%0d data=%0h addr=%0h, expected v=1 id=2 data=3f addr=3f",
                             k, m_valid, m_id, m_data, lut_addr);
                end
            end
        end
    endtask

    task automatic test_random_cke();
        exp_t       issue_m;
        exp_t       pipe_m;
        logic [1:0] last_m;
        logic [1:0] g;
        logic [5:0] a;
        logic [3:0] exp_ready;
        int         accepted;
        int         results;
        do_reset();
        issue_m     = '0;
        pipe_m      = '0;
        last_m      = 2'd3;
        accepted    = 0;
        results     = 0;
        s_req_valid = 4'b1111;
        for (int cyc = 0; cyc < 6000 && accepted < 4096; cyc++) begin
            cke        = ($urandom_range(0, 9) != 0);
            s_req_addr = 24'($urandom);
            g          = last_m + 2'd1;
            a          = s_req_addr[g*6 +: 6];
            exp_ready  = cke ? (4'b0001 << g) : 4'b0000;
            #1;
            checks++;
            if (s_req_ready !== exp_ready) begin
                failures++;
                $display("FAIL cke_grant[%0d]: got ready=%b, expected %b (cke=%b)", cyc, s_req_ready, exp_ready, cke);
            end
            @(posedge clk);
            #1;
            if (cke) begin
                pipe_m  = issue_m;
                issue_m = '{v: 1'b1, id: g, data: {2'b00, a}};
                last_m  = g;
                accepted++;
            end
            checks++;
            if (m_valid !== pipe_m.v || (pipe_m.v && (m_id !== pipe_m.id || m_data !== pipe_m.data))) begin
                failures++;
                $display("FAIL cke_result[%0d]: got v=%b id=%0d data=%0h, expected v=%b id=%0d data=%0h",
                         cyc, m_valid, m_id, m_data, pipe_m.v, pipe_m.id, pipe_m.data);
            end else if (pipe_m.v && cke) begin
                results++;
            end
        end
        checks++;
        if (accepted != 4096) begin
            failures++;
            $display("FAIL cke_budget: got %0d lookups issued, expected 4096", accepted);
        end
        cke         = 1'b1;
        s_req_valid = 4'b0000;
        for (int d = 0; d < 2; d++) begin
            @(posedge clk);
            #1;
            pipe_m  = issue_m;
            issue_m = '0;
            checks++;
            if (m_valid !== pipe_m.v || (pipe_m.v && (m_id !== pipe_m.id || m_data !== pipe_m.data))) begin
                failures++;
                $display("FAIL cke_drain[%0d]: got v=%b id=%0d data=%0h, expected v=%b id=%0d data=%0h",
                         d, m_valid, m_id, m_data, pipe_m.v, pipe_m.id, pipe_m.data);
            end else if (pipe_m.v) begin
                results++;
            end
        end
        checks++;
        if (results != 4096) begin
            failures++;
            $display("FAIL cke_scoreboard: got %0d matching results, expected 4096", results);
        end
    endtask

    task automatic test_reset_in_flight();
        do_reset();
        s_req_addr  = {6'd40, 6'd20, 6'd10, 6'd5};
        s_req_valid = 4'b1111;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checks++;
        if (m_valid !== 1'b1 || m_id !== 2'd0) begin
            failures++;
            $display("FAIL inflight_setup: got v=%b id=%0d, expected v=1 id=0", m_valid, m_id);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (m_valid !== 1'b0 || lut_valid !== 1'b0 || lut_clear !== 1'b1) begin
            failures++;
            $display("FAIL inflight_reset: got m_valid=%b lut_valid=%b lut_clear=%b, expected 0 0 1",
                     m_valid, lut_valid, lut_clear);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (s_req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL inflight_regrant: got ready=%b, expected 0001", s_req_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (m_valid !== 1'b0) begin
            failures++;
            $display("FAIL inflight_stale: got m_valid=%b, expected 0", m_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (m_valid !== 1'b1 || m_id !== 2'd0 || m_data !== 8'd5) begin
            failures++;
            $display("FAIL inflight_resume: got v=%b id=%0d data=%0d, expected v=1 id=0 data=5",
                     m_valid, m_id, m_data);
        end
    endtask

`ifdef ELIXIRCHIP_ES1_SPU_LUT_ARB_URGENT0_EN
    task automatic test_urgent0();
        do_reset();
        s_req_addr  = {6'd40, 6'd20, 6'd10, 6'd5};
        s_req_valid = 4'b0011;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (s_req_ready !== 4'b0001) begin
                failures++;
                $display("FAIL urgent_grant[%0d]: got ready=%b, expected 0001", k, s_req_ready);
            end
            @(posedge clk);
            #1;
            if (k >= 1) begin
                checks++;
                if (m_valid !== 1'b1 || m_id !== 2'd0 || m_data !== 8'd5) begin
                    failures++;
                    $display("FAIL urgent_result[%0d]: got v=%b id=%0d data=%0d, expected v=1 id=0 data=5",
                             k, m_valid, m_id, m_data);
                end
            end
        end
        s_req_valid = 4'b0010;
        #1;
        checks++;
        if (s_req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL urgent_release: got ready=%b, expected 0010", s_req_ready);
        end
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checks++;
        if (m_valid !== 1'b1 || m_id !== 2'd1 || m_data !== 8'd10) begin
            failures++;
            $display("FAIL urgent_release_result: got v=%b id=%0d data=%0d, expected v=1 id=1 data=10",
                     m_valid, m_id, m_data);
        end
    endtask
`endif

    initial begin
        reset       = 1'b1;
        cke         = 1'b0;
        s_req_addr  = '0;
        s_req_valid = '0;
        test_reset();
        test_round_robin();
        test_single_requester();
        test_random_cke();
        test_reset_in_flight();
`ifdef ELIXIRCHIP_ES1_SPU_LUT_ARB_URGENT0_EN
        test_urgent0();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
